// File: rtl/cargador_programa.sv
// Program loader: receives a length-prefixed, checksummed byte stream and
// writes the assembled 32-bit little-endian words into instruction memory,
// holding the core in reset until a load completes with a good checksum.
module cargador_programa (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  // Only N <= 256 ever proceeds to DATA, so 9 bits of length suffice.
  logic [8:0]  len_q, len_d;
  // 9 bits so that the count after word 255 reads 256, not 0.
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic        imem_we_q, imem_we_d;
  logic [7:0]  imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;

  logic        accept;
  logic [15:0] len_full;
  logic [8:0]  word_cnt_inc;

  assign in_ready     = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CHECK);
  assign accept       = in_valid && in_ready;
  assign len_full     = {in_byte, len_q[7:0]};
  assign word_cnt_inc = word_cnt_q + 9'd1;

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign cpu_rst    = (state_q != DONE);

  // State and datapath registers; reset abandons any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // Next-state logic: stream parsing, word assembly and checksum tracking.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          len_d      = '0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end

      LEN_LO: begin
        if (accept) begin
          len_d   = {1'b0, in_byte};
          state_d = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          len_d = len_full[8:0];
          if (len_full > 16'd256) begin
            state_d = ERR;
          end else if (len_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_buf_d[7:0]   = in_byte;
            2'd1: word_buf_d[15:8]  = in_byte;
            2'd2: word_buf_d[23:16] = in_byte;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_cnt_q[7:0];
              imem_wdata_d = {in_byte, word_buf_q};
              word_cnt_d   = word_cnt_inc;
              if (word_cnt_inc == len_q) begin
                state_d = CHECK;
              end
            end
          endcase
        end
      end

      CHECK: begin
        if (accept) begin
          state_d = (in_byte == csum_q) ? DONE : ERR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa: a stream-level reference model predicts the
// instruction-memory writes and the final done/error outcome of each load.
module tb_cargador_programa;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t seen_q[$];
  wr_t ref_q[$];
  wr_t e_cmp;
  wr_t s_cmp;
  logic [7:0]  hold_a;
  logic [31:0] hold_d;
  logic        prev_we;

  always #5 clk = ~clk;

  cargador_programa dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model's expected write list.
  always @(negedge clk) begin
    if (rst) begin
      hold_a  = '0;
      hold_d  = '0;
      prev_we = 1'b0;
    end else begin
      chk("done_error_exclusive", {31'd0, done & error}, 32'd0);
      chk("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, !done});
      if (imem_we) begin
        chk("we_single_pulse", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e_cmp = exp_q.pop_front();
          chk("wr_addr", {24'd0, imem_addr}, {24'd0, e_cmp.a});
          chk("wr_data", imem_wdata, e_cmp.d);
        end
        s_cmp.a = imem_addr;
        s_cmp.d = imem_wdata;
        seen_q.push_back(s_cmp);
        hold_a = imem_addr;
        hold_d = imem_wdata;
      end else begin
        chk("hold_addr", {24'd0, imem_addr}, {24'd0, hold_a});
        chk("hold_data", imem_wdata, hold_d);
      end
      prev_we = imem_we;
    end
  end

  // Reference model: parse the stream by its format rules.
  task automatic model_load(input bq_t s, output logic exp_done, output logic exp_err);
    int n;
    logic [7:0] x;
    wr_t w;
    n = {s[1], s[0]};
    x = '0;
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (n > 256) return;
    for (int i = 0; i < n; i++) begin
      w.a = i[7:0];
      w.d = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      for (int k = 0; k < 4; k++) x ^= s[2+4*i+k];
      exp_q.push_back(w);
    end
    exp_done = (s[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  function automatic bq_t make_stream(input int n, input bit bad);
    bq_t s;
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      s.push_back(b);
      x ^= b;
    end
    s.push_back(bad ? ~x : x);
    return s;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
  endtask

  task automatic send_bytes(input bq_t s, input int count, input int gap_pct);
    int t;
    for (int i = 0; i < count; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = s[i];
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got in_ready 0 expected 1 at byte %0d", i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full load: model prediction, start pulse, stream, then outcome check.
  task automatic run_load(input bq_t s, input int gap_pct);
    logic ed;
    logic ee;
    int   nbytes;
    model_load(s, ed, ee);
    nbytes = ({s[1], s[0]} > 256) ? 2 : s.size();
    seen_q.delete();
    do_start();
    send_bytes(s, nbytes, gap_pct);
    chk("final_done", {31'd0, done}, {31'd0, ed});
    chk("final_error", {31'd0, error}, {31'd0, ee});
    chk("all_writes_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    bq_t s;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst = 1'b0;

    // Single word with good checksum.
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    run_load(s, 0);
    chk("w1_count", seen_q.size(), 32'd1);
    if (seen_q.size() == 1) begin
      chk("w1_addr", {24'd0, seen_q[0].a}, 32'd0);
      chk("w1_data", seen_q[0].d, 32'h00A00513);
    end
    chk("w1_done", {31'd0, done}, 32'd1);
    chk("w1_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Bad checksum, then recovery with a correct stream.
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
    run_load(s, 0);
    chk("bad_error", {31'd0, error}, 32'd1);
    chk("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    run_load(s, 0);
    chk("recover_done", {31'd0, done}, 32'd1);

    // Length too large: error straight after the length bytes.
    s = '{8'h01, 8'h01};
    run_load(s, 0);
    chk("n257_error", {31'd0, error}, 32'd1);
    chk("n257_writes", seen_q.size(), 32'd0);

    // Maximum length.
    s = make_stream(256, 1'b0);
    run_load(s, 0);
    chk("n256_writes", seen_q.size(), 32'd256);
    if (seen_q.size() == 256) chk("n256_last_addr", {24'd0, seen_q[255].a}, 32'hFF);
    chk("n256_done", {31'd0, done}, 32'd1);

    // Zero length.
    s = '{8'h00, 8'h00, 8'h00};
    run_load(s, 0);
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_writes", seen_q.size(), 32'd0);
    s = '{8'h00, 8'h00, 8'h01};
    run_load(s, 0);
    chk("n0_bad_error", {31'd0, error}, 32'd1);

    // Same 3-word stream with and without input gaps.
    s = make_stream(3, 1'b0);
    run_load(s, 0);
    ref_q = seen_q;
    run_load(s, 50);
    chk("gap_writes", seen_q.size(), ref_q.size());
    if (seen_q.size() == 3 && ref_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("gap_addr", {24'd0, seen_q[i].a}, i);
        chk("gap_data", seen_q[i].d, ref_q[i].d);
      end
    end

    // Reset after two data bytes: nothing written, then a clean reload.
    s = make_stream(3, 1'b0);
    seen_q.delete();
    exp_q.delete();
    do_start();
    send_bytes(s, 4, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    chk("midrst_writes", seen_q.size(), 32'd0);
    run_load(s, 0);
    chk("midrst_reload_done", {31'd0, done}, 32'd1);
    chk("midrst_reload_writes", seen_q.size(), 32'd3);

    // Randomized loads with random lengths, gaps and checksum corruption.
    for (int r = 0; r < 12; r++) begin
      s = make_stream(int'($urandom_range(0, 8)), bit'($urandom_range(0, 3) == 0));
      run_load(s, int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
